// File: rtl/crop_burst_scheduler.sv
// Crop-window burst scheduler: tracks frame position of each camera beat, latches the crop
// origin at frame start and forwards only bursts overlapping the window, with keep mask and framing.
module crop_burst_scheduler #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int PIXELS_PER_BURST = 16,
  parameter int USER_WIDTH       = 4,
  parameter int IN_ROWS          = 100,
  parameter int IN_COLS          = 160,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48
) (
  input  logic                                        clk,
  input  logic                                        srst,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0]                       s_axis_tuser,
  input  logic [$clog2(IN_COLS)-1:0]                  crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0]                  crop_y0,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] m_axis_tdata,
  output logic [PIXELS_PER_BURST-1:0]                 m_axis_tkeep,
  output logic [USER_WIDTH-1:0]                       m_axis_tuser,
  output logic                                        frame_done,
  output logic                                        err_sof_mid,
  output logic                                        err_line_len
);

  localparam int PPB = PIXELS_PER_BURST;
  localparam int DW  = PIXEL_BIT_WIDTH * PPB;
  localparam int NB  = IN_COLS / PPB;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int XW  = $clog2(IN_COLS);
  localparam int RW  = $clog2(IN_ROWS);
  localparam int CW  = $clog2(IN_COLS + PPB) + 1;
  localparam int RCW = $clog2(IN_ROWS + OUT_ROWS) + 1;

  localparam logic [BW-1:0]  LAST_B   = BW'(NB - 1);
  localparam logic [RCW-1:0] LAST_ROW = RCW'(IN_ROWS - 1);
  localparam logic [CW-1:0]  MAX_X0   = CW'(IN_COLS - OUT_COLS);
  localparam logic [RCW-1:0] MAX_Y0   = RCW'(IN_ROWS - OUT_ROWS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x0s_q;
  logic [RW-1:0]   y0s_q;
  logic [BW-1:0]   bcnt_q;
  logic [RW-1:0]   row_q;

  logic            accept, sof, eol, evaluate, kept, frame_end;
  logic [CW-1:0]   x0_new, x0_e, c;
  logic [RCW-1:0]  y0_new, y0_e, row_e;
  logic [BW-1:0]   bcnt_e;
  logic [PPB-1:0]  keep_vec;
  logic [USER_WIDTH-1:0] user_vec;
  logic            unused_user;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign unused_user   = ^{s_axis_tuser[USER_WIDTH-1:3], s_axis_tuser[1]};

  // A frame-start beat is evaluated as row 0 burst 0 against the origin being latched now.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accept   = s_axis_tvalid && s_axis_tready;
    sof      = s_axis_tuser[0];
    eol      = s_axis_tuser[2];
    x0_new   = (CW'(crop_x0) > MAX_X0) ? MAX_X0 : CW'(crop_x0);
    y0_new   = (RCW'(crop_y0) > MAX_Y0) ? MAX_Y0 : RCW'(crop_y0);
    x0_e     = sof ? x0_new : CW'(x0s_q);
    y0_e     = sof ? y0_new : RCW'(y0s_q);
    row_e    = sof ? '0 : RCW'(row_q);
    bcnt_e   = sof ? '0 : bcnt_q;
    evaluate = sof || (state_q == ACTIVE);
    c        = CW'(bcnt_e) * CW'(PPB);
    kept     = evaluate
            && (row_e >= y0_e) && (row_e <= y0_e + RCW'(OUT_ROWS - 1))
            && (c <= x0_e + CW'(OUT_COLS - 1)) && (c + CW'(PPB - 1) >= x0_e);
    for (int i = 0; i < PPB; i++) begin
      keep_vec[i] = (c + CW'(i) >= x0_e) && (c + CW'(i) <= x0_e + CW'(OUT_COLS - 1));
    end
    user_vec    = '0;
    user_vec[0] = (c <= x0_e) && (row_e == y0_e);
    user_vec[2] = (c + CW'(PPB - 1) >= x0_e + CW'(OUT_COLS - 1));
    user_vec[3] = user_vec[2] && (row_e == y0_e + RCW'(OUT_ROWS - 1));
    frame_end   = accept && evaluate && eol && (row_e == LAST_ROW);

    state_d = state_q;
    if (accept && evaluate) begin
      state_d = frame_end ? IDLE : ACTIVE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      x0s_q        <= '0;
      y0s_q        <= '0;
      bcnt_q       <= '0;
      row_q        <= '0;
      frame_done   <= 1'b0;
      err_sof_mid  <= 1'b0;
      err_line_len <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (accept && sof) begin
        x0s_q <= XW'(x0_new);
        y0s_q <= RW'(y0_new);
        if (state_q == ACTIVE) err_sof_mid <= 1'b1;
      end
      if (accept && evaluate) begin
        if (eol) begin
          bcnt_q <= '0;
          row_q  <= (row_e == LAST_ROW) ? '0 : RW'(row_e + RCW'(1));
        end else begin
          row_q <= RW'(row_e);
          if (bcnt_e == LAST_B) begin
            bcnt_q       <= bcnt_e;
            err_line_len <= 1'b1;
          end else begin
            bcnt_q <= bcnt_e + BW'(1);
          end
        end
      end
    end
  end

  // Single output register; the slot is free whenever s_axis_tready is high.
  always_ff @(posedge clk) begin
    if (srst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= kept;
      if (kept) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= keep_vec;
        m_axis_tuser <= user_vec;
      end
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
